// File: rtl/high_score_tracker.sv
`default_nettype none
// ============================================================================
// high_score_tracker : latches each final game score, keeps the best score
//                      and blinks the score displays after a new record.
// Rev 1.0
// ============================================================================
module high_score_tracker #(
  parameter int MAX_SCORE      = 9999,
  parameter int CLKS_PER_MS    = 50000,
  parameter int BLINK_MS       = 250,
  parameter int RESULT_HOLD_MS = 5000,
  localparam int SCORE_W       = $clog2(MAX_SCORE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_in_progress,
  input  logic [SCORE_W-1:0] score,
  input  logic               clear_high_score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] last_score,
  output logic               new_record,
  output logic               display_blank,
  output logic               result_valid
);

  localparam int HOLD_CYC  = RESULT_HOLD_MS * CLKS_PER_MS;
  localparam int BLINK_CYC = BLINK_MS * CLKS_PER_MS;
  localparam int HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int BLINK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [HOLD_W-1:0]  c_hold_last  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_CYC - 1);
  localparam logic [SCORE_W-1:0] c_max_score  = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  state_t               r_state, w_state_n;
  logic [SCORE_W-1:0]   r_high, w_high_n;
  logic [SCORE_W-1:0]   r_last, w_last_n;
  logic                 r_rec, w_rec_n;
  logic                 r_blank, w_blank_n;
  logic                 r_valid, w_valid_n;
  logic [HOLD_W-1:0]    r_hold, w_hold_n;
  logic [BLINK_W-1:0]   r_blink, w_blink_n;
  logic [SCORE_W-1:0]   w_capped;

  assign w_capped = (score > c_max_score) ? c_max_score : score;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_high  <= '0;
      r_last  <= '0;
      r_rec   <= 1'b0;
      r_blank <= 1'b0;
      r_valid <= 1'b0;
      r_hold  <= '0;
      r_blink <= '0;
    end else begin
      r_state <= w_state_n;
      r_high  <= w_high_n;
      r_last  <= w_last_n;
      r_rec   <= w_rec_n;
      r_blank <= w_blank_n;
      r_valid <= w_valid_n;
      r_hold  <= w_hold_n;
      r_blink <= w_blink_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_high_n  = r_high;
    w_last_n  = r_last;
    w_rec_n   = r_rec;
    w_blank_n = r_blank;
    w_valid_n = 1'b0;
    w_hold_n  = r_hold;
    w_blink_n = r_blink;

    case (r_state)
      S_IDLE: begin
        w_rec_n   = 1'b0;
        w_blank_n = 1'b0;
        w_hold_n  = '0;
        w_blink_n = '0;
        if (clear_high_score) w_high_n = '0;
        if (game_in_progress) w_state_n = S_PLAYING;
      end

      S_PLAYING: begin
        w_hold_n  = '0;
        w_blink_n = '0;
        w_rec_n   = 1'b0;
        w_blank_n = 1'b0;
        if (!game_in_progress) begin
          w_state_n = S_RESULT;
          w_last_n  = w_capped;
          w_valid_n = 1'b1;
          // Strictly greater: a tie is not a record.
          if (w_capped > r_high) begin
            w_high_n = w_capped;
            w_rec_n  = 1'b1;
          end
        end
      end

      S_RESULT: begin
        if (game_in_progress) begin
          w_state_n = S_PLAYING;
          w_rec_n   = 1'b0;
          w_blank_n = 1'b0;
          w_hold_n  = '0;
          w_blink_n = '0;
        end else if (r_hold == c_hold_last) begin
          w_state_n = S_IDLE;
          w_rec_n   = 1'b0;
          w_blank_n = 1'b0;
          w_hold_n  = '0;
          w_blink_n = '0;
        end else begin
          w_hold_n = r_hold + 1'b1;
          if (r_blink == c_blink_last) begin
            w_blink_n = '0;
            if (r_rec) w_blank_n = ~r_blank;
          end else begin
            w_blink_n = r_blink + 1'b1;
          end
        end
        // Clearing the record also stops the blink for the rest of RESULT.
        if (clear_high_score) begin
          w_high_n  = '0;
          w_rec_n   = 1'b0;
          w_blank_n = 1'b0;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign high_score    = r_high;
  assign last_score    = r_last;
  assign new_record    = r_rec;
  assign display_blank = r_blank;
  assign result_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_high_score_tracker.sv
`default_nettype none
// ============================================================================
// tb_high_score_tracker : directed scenarios plus random play, checked every
//                         cycle against a behavioural model of the tracker.
// Rev 1.0
// ============================================================================
module tb_high_score_tracker;

  localparam int MAX_SCORE      = 9999;
  localparam int CLKS_PER_MS    = 2;
  localparam int BLINK_MS       = 2;
  localparam int RESULT_HOLD_MS = 10;
  localparam int SCORE_W        = $clog2(MAX_SCORE + 1);
  localparam int HOLD           = RESULT_HOLD_MS * CLKS_PER_MS;
  localparam int BLINK          = BLINK_MS * CLKS_PER_MS;

  localparam int M_IDLE    = 0;
  localparam int M_PLAYING = 1;
  localparam int M_RESULT  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               game_in_progress = 1'b0;
  logic               clear_high_score = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic [SCORE_W-1:0] high_score;
  logic [SCORE_W-1:0] last_score;
  logic               new_record;
  logic               display_blank;
  logic               result_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: mode, stored scores and the age (cycles since capture) of RESULT.
  int m_mode = M_IDLE;
  int m_high = 0;
  int m_last = 0;
  int m_rec  = 0;
  int m_valid = 0;
  int m_age  = 0;

  high_score_tracker #(
    .MAX_SCORE      (MAX_SCORE),
    .CLKS_PER_MS    (CLKS_PER_MS),
    .BLINK_MS       (BLINK_MS),
    .RESULT_HOLD_MS (RESULT_HOLD_MS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .game_in_progress (game_in_progress),
    .score            (score),
    .clear_high_score (clear_high_score),
    .high_score       (high_score),
    .last_score       (last_score),
    .new_record       (new_record),
    .display_blank    (display_blank),
    .result_valid     (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Blink phase follows directly from how long RESULT has been showing.
  function automatic int model_blank();
    return (m_mode == M_RESULT && m_rec == 1 && ((m_age / BLINK) % 2) == 1) ? 1 : 0;
  endfunction

  initial forever begin
    int cap;
    @(posedge clk);
    m_valid = 0;
    if (!rst) begin
      m_mode = M_IDLE; m_high = 0; m_last = 0; m_rec = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (clear_high_score) m_high = 0;
          if (game_in_progress) m_mode = M_PLAYING;
        end
        M_PLAYING: begin
          if (!game_in_progress) begin
            cap = (int'(score) > MAX_SCORE) ? MAX_SCORE : int'(score);
            m_last  = cap;
            m_valid = 1;
            m_rec   = (cap > m_high) ? 1 : 0;
            if (cap > m_high) m_high = cap;
            m_age  = 0;
            m_mode = M_RESULT;
          end
        end
        default: begin
          if (clear_high_score) begin
            m_high = 0;
            m_rec  = 0;
          end
          if (game_in_progress) begin
            m_mode = M_PLAYING;
            m_rec  = 0;
          end else if (m_age + 1 == HOLD) begin
            m_mode = M_IDLE;
            m_rec  = 0;
          end else begin
            m_age++;
          end
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("high_score",    int'(high_score),    m_high);
      check("last_score",    int'(last_score),    m_last);
      check("new_record",    int'(new_record),    m_rec);
      check("display_blank", int'(display_blank), model_blank());
      check("result_valid",  int'(result_valid),  m_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    game_in_progress = 1'b0;
    clear_high_score = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Returns right after the capture edge (RESULT age 0).
  task automatic play_game(input int final_score, input int len);
    game_in_progress = 1'b1;
    repeat (len) begin
      score = SCORE_W'($urandom_range(0, MAX_SCORE));
      tick();
    end
    score = SCORE_W'(final_score);
    game_in_progress = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("reset high_score", int'(high_score), 0);
    check("reset last_score", int'(last_score), 0);
    check("reset flags", int'({new_record, display_blank, result_valid}), 0);

    // Single game at 120 from reset: record, blink every 4 cycles, IDLE after 20.
    play_game(120, 5);
    check("g120 last_score", int'(last_score), 120);
    check("g120 high_score", int'(high_score), 120);
    check("g120 result_valid", int'(result_valid), 1);
    check("g120 new_record", int'(new_record), 1);
    check("g120 blank age0", int'(display_blank), 0);
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (k == 1)  check("g120 valid drops", int'(result_valid), 0);
      if (k == 4)  check("g120 blank age4", int'(display_blank), 1);
      if (k == 8)  check("g120 blank age8", int'(display_blank), 0);
      if (k == 12) check("g120 blank age12", int'(display_blank), 1);
      if (k == 19) check("g120 record held", int'(new_record), 1);
      if (k == 20) check("g120 idle flags", int'({new_record, display_blank, result_valid}), 0);
    end

    // 80 then 120 then 120 again: the tie is not a record.
    do_reset();
    play_game(80, 3);
    check("g80 high_score", int'(high_score), 80);
    repeat (HOLD) tick();
    play_game(120, 4);
    check("g80_120 high_score", int'(high_score), 120);
    check("g80_120 new_record", int'(new_record), 1);
    repeat (HOLD) tick();
    play_game(120, 4);
    check("tie new_record", int'(new_record), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) check("tie blank", int'(display_blank), 0);
    end
    repeat (HOLD) tick();

    // Over-range score saturates.
    play_game(16383, 2);
    check("sat last_score", int'(last_score), 9999);
    check("sat high_score", int'(high_score), 9999);
    repeat (HOLD) tick();

    // Restart from RESULT six cycles in.
    do_reset();
    play_game(50, 3);
    repeat (6) tick();
    check("restart blank before", int'(display_blank), 1);
    game_in_progress = 1'b1;
    tick();
    check("restart new_record", int'(new_record), 0);
    check("restart blank", int'(display_blank), 0);
    check("restart high_score", int'(high_score), 50);

    // Clear ignored while playing, honoured in RESULT.
    clear_high_score = 1'b1;
    tick();
    clear_high_score = 1'b0;
    check("clear in play ignored", int'(high_score), 50);
    play_game(70, 2);
    check("g70 new_record", int'(new_record), 1);
    tick();
    clear_high_score = 1'b1;
    tick();
    clear_high_score = 1'b0;
    check("clear result high", int'(high_score), 0);
    check("clear result record", int'(new_record), 0);
    check("clear keeps last", int'(last_score), 70);
    repeat (HOLD) tick();

    // Reset mid-blink.
    play_game(200, 2);
    repeat (5) tick();
    check("midblink blank", int'(display_blank), 1);
    rst = 1'b0;
    tick();
    check("midblink rst outputs",
          int'({high_score, last_score, new_record, display_blank, result_valid}), 0);
    rst = 1'b1;

    // Random play checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      if (game_in_progress) begin
        if ($urandom_range(0, 7) == 0) game_in_progress = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        game_in_progress = 1'b1;
      end
      if ($urandom_range(0, 3) == 0)
        score = SCORE_W'($urandom_range(0, 16383));
      clear_high_score = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    clear_high_score = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/high_score_tracker.md
HIGH_SCORE_TRACKER -- requirements
Module: high_score_tracker

Interface
REQ-001 Parameter MAX_SCORE, default 9999: largest representable score; SCORE_W = $clog2(MAX_SCORE+1).
REQ-002 Parameter CLKS_PER_MS, default 50000: clk cycles per millisecond.
REQ-003 Parameter BLINK_MS, default 250: half-period of the new-record blink.
REQ-004 Parameter RESULT_HOLD_MS, default 5000: time spent in RESULT before returning to IDLE.
REQ-005 clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-low.
REQ-007 game_in_progress  input  1  high while a game runs; driven by the game FSM.
REQ-008 score  input  SCORE_W  running score from the score counter.
REQ-009 clear_high_score  input  1  debounced single-cycle pulse that erases the stored high score.
REQ-010 high_score  output  SCORE_W  best final score since reset or clear.
REQ-011 last_score  output  SCORE_W  final score of the most recent completed game.
REQ-012 new_record  output  1  high while RESULT shows a game that beat the previous high score.
REQ-013 display_blank  output  1  blink enable for the score displays (1 = blank).
REQ-014 result_valid  output  1  one-cycle pulse when last_score is captured.

Function
REQ-015 The block shall implement the states IDLE, PLAYING and RESULT.
REQ-016 IDLE -> PLAYING shall occur on the cycle game_in_progress is sampled 1.
REQ-017 PLAYING -> RESULT shall occur on the first cycle game_in_progress is sampled 0 (game end).
- On that same edge, last_score shall load the sampled score, saturated to MAX_SCORE.
- result_valid shall be 1 for exactly the following cycle.
REQ-018 On the capture edge, if the captured score is greater than high_score, high_score shall take the captured score and new_record shall be set to 1.
- A captured score equal to or less than high_score shall leave high_score unchanged and new_record at 0.
REQ-019 RESULT shall hold a timer of RESULT_HOLD_MS*CLKS_PER_MS cycles. When it expires, the block shall go to IDLE and clear new_record and display_blank on that same edge.
REQ-020 While in RESULT with new_record=1, display_blank shall toggle every BLINK_MS*CLKS_PER_MS cycles, starting at 0 on RESULT entry. In every other case, display_blank shall be 0.
REQ-021 If game_in_progress is sampled 1 while in RESULT, the block shall go to PLAYING immediately. new_record, display_blank and the timers shall clear; high_score and last_score shall be kept.
REQ-022 clear_high_score shall set high_score to 0 in IDLE or RESULT, and in RESULT shall also clear new_record and display_blank.
- clear_high_score shall be ignored in PLAYING, so a capture never coincides with a clear.
REQ-023 last_score shall change only on the capture edge.
REQ-024 Counters shall be sized with $clog2 of their terminal count and shall never wrap within a state.

Reset
REQ-025 While rst=0 at a clock edge, the block shall enter IDLE and set high_score=0, last_score=0, new_record=0, display_blank=0, result_valid=0, and both timers to 0.
REQ-026 rst=0 in any state, including mid-game or mid-blink, shall take priority over every other input on that edge.
REQ-027 The first game_in_progress=1 sampled after rst returns to 1 shall be handled per REQ-016.

Verification
Bench parameters for all scenarios: CLKS_PER_MS=2, BLINK_MS=2, RESULT_HOLD_MS=10.
REQ-028 Reset, then play a game ending with score=120 -> last_score=120, high_score=120, result_valid pulses once, new_record=1, display_blank toggles every 4 cycles, IDLE after 20 cycles with all flags 0.
REQ-029 Play a game ending at 80, then a game ending at 120 -> after the second game high_score=120 and new_record=1. Then play a game ending at 120 -> new_record=0, display_blank stays 0.
REQ-030 Drive score=16383 (above MAX_SCORE) at game end -> last_score=9999, high_score=9999.
REQ-031 Set high_score=50, then raise game_in_progress 6 cycles into RESULT -> PLAYING next cycle, new_record=0, display_blank=0, high_score=50 kept.
REQ-032 Pulse clear_high_score once in PLAYING and once in RESULT -> the PLAYING pulse has no effect; the RESULT pulse gives high_score=0 and new_record=0 on the next cycle.
REQ-033 Assert rst=0 mid-blink in RESULT -> all outputs 0 and state IDLE on the next edge.
